// File: rtl/data_memory_mp.sv
// data_memory_mp: parametrised 1-write / 2-read data memory.
// Registered reads with per-port valid pulses, write-first bypass and a
// zero-fill sweep that runs after reset and on request.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_CLEAR| sweep writes 0 to mem[clr_addr] each cycle, busy=1
// ST_IDLE | normal operation, writes and reads served from the array
module data_memory_mp #(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_req,
   output logic              busy,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   output logic              wr_dropped,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   output logic              rvalid1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   output logic              rvalid2
);

   // Addresses are compared one bit wider so a non-power-of-two DEPTH can be
   // detected without truncating the bound.
   localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] clr_addr;
   logic [ADDR_W-1:0] clr_addr_nxt;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              waddr_ok;
   logic              raddr1_ok;
   logic              raddr2_ok;
   logic              wr_do;
   logic              clr_we;
   logic [DATA_W-1:0] rd_val1;
   logic [DATA_W-1:0] rd_val2;

   assign waddr_ok  = ({1'b0, waddr}  < DEPTH_C);
   assign raddr1_ok = ({1'b0, raddr1} < DEPTH_C);
   assign raddr2_ok = ({1'b0, raddr2} < DEPTH_C);

   // State register and sweep address; reset restarts the sweep from 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_CLEAR;
         clr_addr <= '0;
      end else begin
         state    <= state_nxt;
         clr_addr <= clr_addr_nxt;
      end
   end

   // Next-state: sweep walks 0..DEPTH-1 then returns to idle; clear_req is
   // only honoured from idle so a running sweep is never restarted.
   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      case (state)
         ST_CLEAR: begin
            if (clr_addr == LAST_ADDR) begin
               state_nxt    = ST_IDLE;
               clr_addr_nxt = '0;
            end else begin
               clr_addr_nxt = clr_addr + 1'b1;
            end
         end
         ST_IDLE: begin
            if (clear_req) begin
               state_nxt    = ST_CLEAR;
               clr_addr_nxt = '0;
            end
         end
         default: begin
            state_nxt    = ST_CLEAR;
            clr_addr_nxt = '0;
         end
      endcase
   end

   // FSM outputs: busy flag, sweep write strobe and the user-write qualifier
   // (a clear request in the same cycle takes priority over the write).
   always_comb begin
      busy   = 1'b0;
      clr_we = 1'b0;
      wr_do  = 1'b0;
      case (state)
         ST_CLEAR: begin
            busy   = 1'b1;
            clr_we = 1'b1;
         end
         ST_IDLE: begin
            wr_do = we && !clear_req && waddr_ok;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

   // Array storage, deliberately without reset; the sweep provides known contents.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else if (wr_do) begin
         mem[waddr] <= wdata;
      end
   end

   // Read data selection per port: zero while sweeping or out of range,
   // same-edge write data bypassed, otherwise the stored word.
   always_comb begin
      rd_val1 = '0;
      rd_val2 = '0;
      if (!busy && raddr1_ok) begin
         if (wr_do && (waddr == raddr1)) begin
            rd_val1 = wdata;
         end else begin
            rd_val1 = mem[raddr1];
         end
      end
      if (!busy && raddr2_ok) begin
         if (wr_do && (waddr == raddr2)) begin
            rd_val2 = wdata;
         end else begin
            rd_val2 = mem[raddr2];
         end
      end
   end

   // Registered read outputs and the dropped-write pulse; rdata holds when idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata1     <= '0;
         rdata2     <= '0;
         rvalid1    <= 1'b0;
         rvalid2    <= 1'b0;
         wr_dropped <= 1'b0;
      end else begin
         rvalid1    <= re1;
         rvalid2    <= re2;
         wr_dropped <= we && !wr_do;
         if (re1) begin
            rdata1 <= rd_val1;
         end
         if (re2) begin
            rdata2 <= rd_val2;
         end
      end
   end

endmodule
